// File: rtl/imul_seq_pkg.sv
// Shared definitions for the sequential integer multiplier: op and state
// encodings plus datapath widths.
package imul_seq_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;
  localparam int ITER_W = 6;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Long multiplies write both result words; everything else (including the
  // reserved encoding) behaves as a 32-bit MUL.
  function automatic logic is_long(input op_e op);
    return (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

endpackage

// File: rtl/imul_neg64.sv
// Combinational 64-bit two's-complement negate.
module imul_neg64
  import imul_seq_pkg::*;
(
  input  logic [PROD_W-1:0] i_x,
  output logic [PROD_W-1:0] o_y
);

  assign o_y = ~i_x + PROD_W'(1);

endmodule

// File: rtl/imul_seq.sv
// Sequential radix-2 shift-add multiplier (MUL / UMULL / SMULL).
// SMULL multiplies magnitudes and negates the 64-bit result in FIX.
// Optional macro IMUL_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier is zero instead of always running 32 iterations.
module imul_seq
  import imul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        a_lo,
  input  logic [3:0]        a_hi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] wd4,
  output logic [3:0]        a3,
  output logic [3:0]        a4,
  output logic              we3,
  output logic              long_we
);

  state_e              r_state;
  op_e                 r_op;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [PROD_W-1:0]   r_acc;
  logic [ITER_W-1:0]   r_cnt;
  logic                r_sign;
  logic [3:0]          r_dlo;
  logic [3:0]          r_dhi;
  logic                r_done;
  logic                r_we3;
  logic                r_long_we;
  logic [DATA_W-1:0]   r_wd3;
  logic [DATA_W-1:0]   r_wd4;
  logic [3:0]          r_a3;
  logic [3:0]          r_a4;

  logic                w_smull;
  logic [PROD_W-1:0]   w_neg_a;
  logic [PROD_W-1:0]   w_neg_b;
  logic [PROD_W-1:0]   w_neg_acc;
  logic [PROD_W-1:0]   w_acc_fix;
  logic [PROD_W-1:0]   w_addend;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic                w_early;
  logic                w_unused_hi;

  assign w_smull = (op_e'(op) == OP_SMULL);

  // Magnitudes come from the same negator on zero-extended operands; the low
  // word of -{0,x} is |x| as an unsigned value, so 0x80000000 stays 2^31.
  imul_neg64 u_neg_a (.i_x({{(PROD_W-DATA_W){1'b0}}, a}), .o_y(w_neg_a));
  imul_neg64 u_neg_b (.i_x({{(PROD_W-DATA_W){1'b0}}, b}), .o_y(w_neg_b));
  imul_neg64 u_neg_acc (.i_x(r_acc), .o_y(w_neg_acc));

  assign w_unused_hi = ^{w_neg_a[PROD_W-1:DATA_W], w_neg_b[PROD_W-1:DATA_W]};

  assign w_mag_a   = (w_smull && a[DATA_W-1]) ? w_neg_a[DATA_W-1:0] : a;
  assign w_mag_b   = (w_smull && b[DATA_W-1]) ? w_neg_b[DATA_W-1:0] : b;
  assign w_addend  = {{(PROD_W-DATA_W){1'b0}}, r_mcand} << r_cnt;
  assign w_acc_fix = r_sign ? w_neg_acc : r_acc;

`ifdef IMUL_EARLY_TERM_EN
  assign w_early = (r_mplier == '0);
`else
  assign w_early = 1'b0;
`endif

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign we3     = r_we3;
  assign long_we = r_long_we;
  assign wd3     = r_wd3;
  assign wd4     = r_wd4;
  assign a3      = r_a3;
  assign a4      = r_a4;

  // Control FSM and datapath: accept, iterate, sign-fix, one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MUL;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_dlo     <= '0;
      r_dhi     <= '0;
      r_done    <= 1'b0;
      r_we3     <= 1'b0;
      r_long_we <= 1'b0;
      r_wd3     <= '0;
      r_wd4     <= '0;
      r_a3      <= '0;
      r_a4      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= op_e'(op);
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_sign   <= w_smull & (a[DATA_W-1] ^ b[DATA_W-1]);
            r_dlo    <= a_lo;
            r_dhi    <= a_hi;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_early) begin
            r_state <= ST_FIX;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + w_addend;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + ITER_W'(1);
            if (r_cnt == ITER_W'(DATA_W-1)) r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_acc     <= w_acc_fix;
          r_wd3     <= w_acc_fix[DATA_W-1:0];
          r_wd4     <= w_acc_fix[PROD_W-1:DATA_W];
          r_a3      <= r_dlo;
          r_a4      <= is_long(r_op) ? r_dhi : 4'd0;
          r_done    <= 1'b1;
          r_we3     <= ~is_long(r_op);
          r_long_we <= is_long(r_op);
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_done    <= 1'b0;
          r_we3     <= 1'b0;
          r_long_we <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imul_seq.sv
// Self-checking bench for imul_seq: directed corner cases plus randomized
// operations against an arithmetic reference model.
module tb_imul_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [3:0]  a_lo, a_hi;
  logic        busy, done, we3, long_we;
  logic [31:0] wd3, wd4;
  logic [3:0]  a3, a4;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat;
  logic [31:0] r3, r4;
  logic [3:0]  q3, q4;
  logic        e3, el, da, ba;

  always #5 clk = ~clk;

  imul_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .a_lo(a_lo), .a_hi(a_hi), .busy(busy), .done(done), .wd3(wd3), .wd4(wd4),
    .a3(a3), .a4(a4), .we3(we3), .long_we(long_we)
  );

  // Reference product from plain arithmetic.
  function automatic logic [63:0] model_prod(input logic [1:0] o, input logic [31:0] x, y);
    logic signed [63:0] sx, sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (o == 2'b10) return 64'(sx * sy);
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Cycles from the start-sampling edge to the edge that raises done.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef IMUL_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    m = (o == 2'b10 && y[31]) ? (32'd0 - y) : y;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return (n == 32) ? 33 : n + 2;
`else
    if (o == 2'b11 && y == 32'hFFFF_FFFF) return 33;
    return 33;
`endif
  endfunction

  // Issue one operation and collect what the DUT shows at its done pulse.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, y, input logic [3:0] lo, hi,
                       output int l, output logic [31:0] o3, o4, output logic [3:0] p3, p4,
                       output logic x3, xl, d_after, b_after);
    @(negedge clk);
    op = o; a = x; b = y; a_lo = lo; a_hi = hi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; a_lo = 4'($urandom); a_hi = 4'($urandom);
    l = -1; o3 = '0; o4 = '0; p3 = '0; p4 = '0; x3 = 1'b0; xl = 1'b0;
    for (int k = 1; k <= 100 && l < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        l = k; o3 = wd3; o4 = wd4; p3 = a3; p4 = a4; x3 = we3; xl = long_we;
      end
    end
    @(posedge clk);
    @(negedge clk);
    d_after = done;
    b_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; a_lo = '0; a_hi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, done, we3, long_we} !== 4'b0) begin n_bad++; $display("FAIL reset_ctl got %b exp 0000", {busy, done, we3, long_we}); end
    n_cmp++; if ({wd4, wd3, a4, a3} !== 72'b0) begin n_bad++; $display("FAIL reset_data got %h exp 0", {wd4, wd3, a4, a3}); end
    reset = 1'b0;
  endtask

  task automatic test_umull_max();
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 4'd9, lat, r3, r4, q3, q4, e3, el, da, ba);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL umull_lat got %0d exp 33", lat); end
    n_cmp++; if ({r4, r3} !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL umull_prod got %h exp fffffffe00000001", {r4, r3}); end
    n_cmp++; if ({el, e3} !== 2'b10) begin n_bad++; $display("FAIL umull_we got %b exp 10", {el, e3}); end
    n_cmp++; if ({da, ba} !== 2'b00) begin n_bad++; $display("FAIL umull_pulse got done=%b busy=%b exp 0 0", da, ba); end
  endtask

  task automatic test_smull_neg();
    do_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0005, 4'd2, 4'd7, lat, r3, r4, q3, q4, e3, el, da, ba);
    n_cmp++; if ({r4, r3} !== 64'hFFFF_FFFF_FFFF_FFFB) begin n_bad++; $display("FAIL smull_neg got %h exp fffffffffffffffb", {r4, r3}); end
    n_cmp++; if ({q4, q3} !== 8'h72) begin n_bad++; $display("FAIL smull_dst got a4=%h a3=%h exp 7 2", q4, q3); end
    n_cmp++; if (lat !== exp_lat(2'b10, 32'h5)) begin n_bad++; $display("FAIL smull_lat got %0d exp %0d", lat, exp_lat(2'b10, 32'h5)); end
  endtask

  task automatic test_mul_small();
    do_op(2'b00, 32'd7, 32'd6, 4'd4, 4'd5, lat, r3, r4, q3, q4, e3, el, da, ba);
    n_cmp++; if (r3 !== 32'd42) begin n_bad++; $display("FAIL mul_wd3 got %0d exp 42", r3); end
    n_cmp++; if ({q4, q3} !== 8'h04) begin n_bad++; $display("FAIL mul_dst got a4=%h a3=%h exp 0 4", q4, q3); end
    n_cmp++; if ({el, e3} !== 2'b01) begin n_bad++; $display("FAIL mul_we got %b exp 01", {el, e3}); end
  endtask

  task automatic test_smull_min();
    do_op(2'b10, 32'h8000_0000, 32'h8000_0000, 4'd1, 4'd2, lat, r3, r4, q3, q4, e3, el, da, ba);
    n_cmp++; if ({r4, r3} !== 64'h4000_0000_0000_0000) begin n_bad++; $display("FAIL smull_min got %h exp 4000000000000000", {r4, r3}); end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL smull_min_lat got %0d exp 33", lat); end
  endtask

  task automatic test_early_term();
    int want;
`ifdef IMUL_EARLY_TERM_EN
    want = 3;
`else
    want = 33;
`endif
    do_op(2'b01, 32'd3, 32'd1, 4'd0, 4'd1, lat, r3, r4, q3, q4, e3, el, da, ba);
    n_cmp++; if ({r4, r3} !== 64'd3) begin n_bad++; $display("FAIL early_prod got %h exp 3", {r4, r3}); end
    n_cmp++; if (lat !== want) begin n_bad++; $display("FAIL early_lat got %0d exp %0d", lat, want); end
    do_op(2'b01, 32'h1234_5678, 32'd0, 4'd0, 4'd1, lat, r3, r4, q3, q4, e3, el, da, ba);
    n_cmp++; if ({r4, r3} !== 64'd0) begin n_bad++; $display("FAIL zero_prod got %h exp 0", {r4, r3}); end
    n_cmp++; if (lat !== exp_lat(2'b01, 32'd0)) begin n_bad++; $display("FAIL zero_lat got %0d exp %0d", lat, exp_lat(2'b01, 32'd0)); end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [3:0]  lo, hi;
    logic [63:0] p;
    logic        lng;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom; y = $urandom;
      case (i % 6)
        0: x = 32'h8000_0000;
        1: y = 32'd0;
        2: y = 32'hFFFF_FFFF;
        3: y = 32'($urandom_range(0, 255));
        default: ;
      endcase
      lo = 4'($urandom); hi = 4'($urandom);
      p = model_prod(o, x, y);
      lng = (o == 2'b01) || (o == 2'b10);
      do_op(o, x, y, lo, hi, lat, r3, r4, q3, q4, e3, el, da, ba);
      n_cmp++; if (r3 !== p[31:0]) begin n_bad++; $display("FAIL rnd%0d_wd3 op=%0d a=%h b=%h got %h exp %h", i, o, x, y, r3, p[31:0]); end
      if (lng) begin
        n_cmp++; if (r4 !== p[63:32]) begin n_bad++; $display("FAIL rnd%0d_wd4 op=%0d a=%h b=%h got %h exp %h", i, o, x, y, r4, p[63:32]); end
      end
      n_cmp++; if ({q4, q3} !== {(lng ? hi : 4'd0), lo}) begin n_bad++; $display("FAIL rnd%0d_dst got %h%h exp %h%h", i, q4, q3, (lng ? hi : 4'd0), lo); end
      n_cmp++; if ({el, e3} !== {lng, ~lng}) begin n_bad++; $display("FAIL rnd%0d_we got %b exp %b", i, {el, e3}, {lng, ~lng}); end
      n_cmp++; if (lat !== exp_lat(o, y)) begin n_bad++; $display("FAIL rnd%0d_lat got %0d exp %0d", i, lat, exp_lat(o, y)); end
      repeat (2) @(negedge clk);
      n_cmp++; if (wd3 !== p[31:0]) begin n_bad++; $display("FAIL rnd%0d_hold got %h exp %h", i, wd3, p[31:0]); end
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] p;
    p = model_prod(2'b01, 32'hCAFE_F00D, 32'h8000_0001);
    @(negedge clk);
    op = 2'b01; a = 32'hCAFE_F00D; b = 32'h8000_0001; a_lo = 4'd8; a_hi = 4'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 5) begin op = 2'b10; a = 32'h1111_1111; b = 32'hF000_0000; start = 1'b1; end
      if (k == 8) start = 1'b0;
      if (done) begin lat = k; r3 = wd3; r4 = wd4; end
    end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL ignore_lat got %0d exp 33", lat); end
    n_cmp++; if ({r4, r3} !== p) begin n_bad++; $display("FAIL ignore_prod got %h exp %h", {r4, r3}, p); end
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_queue busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int d0, d1, nd;
    logic [63:0] p;
    p = model_prod(2'b01, 32'h1234_5678, 32'h8000_0001);
    d0 = -1; d1 = -1; nd = 0;
    @(negedge clk);
    op = 2'b01; a = 32'h1234_5678; b = 32'h8000_0001; a_lo = 4'd1; a_hi = 4'd2; start = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        nd++;
        if (d0 < 0) d0 = c; else d1 = c;
        n_cmp++; if ({wd4, wd3} !== p) begin n_bad++; $display("FAIL b2b_prod%0d got %h exp %h", nd, {wd4, wd3}, p); end
      end
    end
    start = 1'b0;
    n_cmp++; if (nd !== 2) begin n_bad++; $display("FAIL b2b_count got %0d exp 2", nd); end
    n_cmp++; if (d0 !== 33 || d1 !== 68) begin n_bad++; $display("FAIL b2b_timing got %0d,%0d exp 33,68", d0, d1); end
    nd = 0;
    while ((busy || done) && nd < 100) begin @(negedge clk); nd++; end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain timeout busy=%b", busy); end
  endtask

  task automatic test_reset_abort();
    int seen;
    logic [63:0] p;
    @(negedge clk);
    op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h8000_0003; a_lo = 4'd5; a_hi = 4'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if ({busy, done, we3, long_we} !== 4'b0) begin n_bad++; $display("FAIL abort_ctl got %b exp 0000", {busy, done, we3, long_we}); end
    n_cmp++; if ({wd4, wd3, a4, a3} !== 72'b0) begin n_bad++; $display("FAIL abort_data got %h exp 0", {wd4, wd3, a4, a3}); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_nodone got %0d active cycles exp 0", seen); end
    p = model_prod(2'b10, 32'hFFFF_FFF9, 32'h0000_0013);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0013, 4'd11, 4'd12, lat, r3, r4, q3, q4, e3, el, da, ba);
    n_cmp++; if ({r4, r3} !== p) begin n_bad++; $display("FAIL abort_after got %h exp %h", {r4, r3}, p); end
    n_cmp++; if (lat !== exp_lat(2'b10, 32'h13)) begin n_bad++; $display("FAIL abort_after_lat got %0d exp %0d", lat, exp_lat(2'b10, 32'h13)); end
  endtask

  initial begin
    test_reset();
    test_umull_max();
    test_smull_neg();
    test_mul_small();
    test_smull_min();
    test_early_term();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imul_seq.md
IMUL_SEQ -- requirements
Module: imul_seq

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 op  input  2  00 MUL (low 32 bits), 01 UMULL, 10 SMULL, 11 reserved (treated as MUL).
REQ-005 a, b  input  32 each  multiplicand and multiplier, captured on accepted start.
REQ-006 a_lo, a_hi  input  4 each  destination register numbers, captured on accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 wd3, wd4  output  32 each  product low and high words; held stable from done until next accepted start.
REQ-010 a3, a4  output  4 each  captured a_lo and a_hi; a4 is 0 for MUL.
REQ-011 we3  output  1  equals done when op is MUL, else 0.
REQ-012 long_we  output  1  equals done when op is UMULL or SMULL, else 0.

Function
REQ-013 States IDLE, RUN, FIX, DONE, 2-bit encoding.
- IDLE->RUN on start.
- RUN->FIX after final iteration.
- FIX->DONE.
- DONE->IDLE unconditionally.
REQ-014 On accept: store operands, op and destinations.
- SMULL: store magnitudes |a|, |b| and sign flag = a[31] XOR b[31].
- Other ops: store operands unsigned, sign flag 0.
- Clear 64-bit accumulator and iteration counter.
REQ-015 RUN, each cycle (radix-2 shift-add):
- If multiplier LSB is 1, add multiplicand, shifted left by the counter, into the 64-bit accumulator.
- Shift multiplier right by 1; increment the 6-bit counter.
REQ-016 RUN exits after exactly 32 iterations; done is high in the cycle after the 33rd rising edge following the start-sampling edge.
REQ-017 FIX: if the sign flag is set, the accumulator becomes its 64-bit two's complement; result registers wd4:wd3 load from the accumulator.
REQ-018 MUL and UMULL results are bit-identical in wd3; SMULL of 0x80000000 x 0x80000000 = 0x4000000000000000 (no overflow on magnitude 2^31).
REQ-019 start while busy is ignored; no queueing.
REQ-020 done, we3 and long_we are never high simultaneously with start acceptance; back-to-back start is accepted on the cycle after done (IDLE).
REQ-021 All arithmetic is unsigned 64-bit; carries beyond bit 63 are discarded.

Reset
REQ-022 reset takes priority over all other inputs and clears the block in the same edge.
- State = IDLE.
- busy, done, we3, long_we = 0.
- wd3, wd4 = 0; a3, a4 = 0; counter and accumulator = 0.
REQ-023 reset during RUN or FIX aborts the operation; no done pulse is produced for it.

Configuration
REQ-024 Macro IMUL_EARLY_TERM_EN.
- Defined: RUN also exits to FIX on any cycle where the remaining multiplier is zero (checked before that iteration); b=0 gives done 2 cycles after start.
- Undefined: fixed 32-iteration latency per REQ-016.
- Results are identical either way.

Structure
REQ-025 A shared package holds:
- op encodings (MUL, UMULL, SMULL);
- state encoding;
- width constants (DATA_W=32, PROD_W=64, ITER_W=6).
REQ-026 Single sub-module imul_neg64 (combinational 64-bit two's-complement negate), used by FIX; the 32-bit magnitude conversion reuses it on zero-extended operands.

Verification
REQ-027 op=UMULL, a=0xFFFFFFFF, b=0xFFFFFFFF -> wd4=0xFFFFFFFE, wd3=0x00000001, long_we=1 for one cycle at cycle 33, we3=0.
REQ-028 op=SMULL, a=0xFFFFFFFF (-1), b=0x00000005 -> wd4=0xFFFFFFFF, wd3=0xFFFFFFFB; a3/a4 equal captured a_lo/a_hi.
REQ-029 op=MUL, a=7, b=6, a_lo=4 -> wd3=42, a3=4, we3=1 pulse, long_we=0.
REQ-030 start held high continuously for 80 cycles -> exactly two completions, the second accepted on the cycle after the first done.
REQ-031 reset asserted 10 cycles into RUN -> no done, busy=0 next cycle, outputs zero; a new start afterwards completes correctly.
REQ-032 IMUL_EARLY_TERM_EN defined, op=UMULL, a=3, b=1 -> wd3=3, done 3 cycles after start; undefined -> done at cycle 33.
